// File: rtl/alu_mul_seq.sv
// Unsigned 32x32 shift-and-add multiply sequencer. Borrows the datapath's shared
// ALU for each partial-sum add through an alu_req/alu_gnt handshake.
module alu_mul_seq #(
    parameter logic [3:0] OP_ADD  = 4'b0001,
    parameter logic [3:0] OP_PASS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod_hi,
    output logic [31:0] prod_lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_carry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_mc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic [31:0] w_mc_next;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;
    logic [5:0]  w_cnt_next;

    // Upper 33 bits of the pre-shift value: {carry,sum} when adding, {0,hi} otherwise.
    logic [32:0] w_upper;
    logic        w_advance;

    assign w_upper   = r_lo[0] ? {alu_carry, alu_result} : {1'b0, r_hi};
    assign w_advance = ~r_lo[0] | alu_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mc    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_mc    <= w_mc_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mc_next    = r_mc;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mc_next    = mcand;
                    w_hi_next    = '0;
                    w_lo_next    = mplier;
                    w_cnt_next   = '0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // A set multiplier bit without a grant stalls with every register held.
                if (w_advance) begin
                    {w_hi_next, w_lo_next} = {w_upper, r_lo[31:1]};
                    w_cnt_next             = r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign prod_hi   = r_hi;
    assign prod_lo   = r_lo;
    assign alu_req   = (r_state == S_RUN) & r_lo[0];
    assign alu_a     = r_hi;
    assign alu_b     = r_mc;
    assign alu_op    = alu_req ? OP_ADD : OP_PASS;
    assign alu_shamt = 5'd0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: a stub ALU, a cycle-level model of the multiply
// transaction, a per-cycle compare process and directed multiply vectors.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_carry;

    int n_checks = 0;
    int n_errors = 0;

    alu_mul_seq #(.OP_ADD(4'b0001), .OP_PASS(4'b0000)) dut (
        .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_result(alu_result),
        .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU owned by the datapath
    logic [32:0] alu_full;
    always_comb begin
        alu_full = {1'b0, alu_a};
        if (alu_op == 4'b0001) alu_full = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_result = alu_full[31:0];
    assign alu_carry  = alu_full[32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: iteration k consumes multiplier bit k; a set bit needs a grant.
    int          m_phase;
    int          m_k;
    logic [31:0] m_mc;
    logic [31:0] m_mp;
    logic [63:0] m_prod;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        int k;
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_mc    <= '0;
            m_mp    <= '0;
            m_prod  <= '0;
            m_valid <= 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_mc    <= mcand;
                    m_mp    <= mplier;
                    m_k     <= 0;
                    m_phase <= 1;
                    m_valid <= 1'b0;
                end
                1: begin
                    k = m_k;
                    if (!m_mp[k] || alu_gnt) k = k + 1;
                    m_k <= k;
                    if (k == 32) begin
                        m_phase <= 2;
                        m_prod  <= {32'b0, m_mc} * {32'b0, m_mp};
                        m_valid <= 1'b1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        if (!rst) begin
            exp_req = (m_phase == 1) ? m_mp[m_k] : 1'b0;
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_phase == 2));
            chk("alu_req", 64'(alu_req), 64'(exp_req));
            chk("alu_op", 64'(alu_op), exp_req ? 64'd1 : 64'd0);
            chk("alu_shamt", 64'(alu_shamt), 64'd0);
            if (m_phase == 1) chk("alu_b", 64'(alu_b), 64'(m_mc));
            if (m_valid) chk("prod", {prod_hi, prod_lo}, m_prod);
        end
    end

    // One multiply: stall_n cycles of withheld grant at the start of RUN,
    // optional second start at cycle restart_at, hand-computed expectations.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int stall_n,
                           input int restart_at, input logic [63:0] exp_prod,
                           input int exp_lat, input int exp_reqs);
        int c, lat, busy_n, req_n, extra;
        @(posedge clk); #1;
        mcand = a; mplier = b; start = 1'b1; alu_gnt = (stall_n == 0);
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; lat = -1; busy_n = 0; req_n = 0;
        while (lat < 0 && c < 200) begin
            if (busy) busy_n++;
            if (alu_req) req_n++;
            if (done) lat = c;
            else begin
                if (c == restart_at) begin
                    mcand = ~a; mplier = 32'h5; start = 1'b1;
                end else start = 1'b0;
                @(posedge clk); #1;
                c++;
                if (c == stall_n) alu_gnt = 1'b1;
            end
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_cycles", 64'(busy_n), 64'(exp_lat + 1));
        chk("req_cycles", 64'(req_n), 64'(exp_reqs));
        chk("prod_lit", {prod_hi, prod_lo}, exp_prod);
        @(posedge clk); #1;
        chk("busy_after", 64'(busy), 64'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) extra++;
            @(posedge clk); #1;
        end
        chk("extra_done", 64'(extra), 64'd0);
        chk("prod_hold", {prod_hi, prod_lo}, exp_prod);
        $display("mul %h x %h stall=%0d -> %h_%h latency=%0d", a, b, stall_n,
                 prod_hi, prod_lo, lat);
    endtask

    initial begin
        start = 1'b0; mcand = '0; mplier = '0; alu_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(alu_req), 64'd0);
        chk("rst_op", 64'(alu_op), 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);

        run_mul(32'h0000000A, 32'h00000003, 0, -1, 64'h00000000_0000001E, 32, 2);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, 64'hFFFFFFFE_00000001, 32, 32);
        run_mul(32'h12345678, 32'h00000000, 0, -1, 64'h0, 32, 0);
        run_mul(32'h00000007, 32'h00000005, 5, -1, 64'h00000000_00000023, 37, 7);
        run_mul(32'h00010001, 32'h0000FFFF, 0, 10, 64'h00000000_FFFFFFFF, 32, 16);

        // Abort a multiply with reset mid-cycle, 10 cycles into RUN
        @(posedge clk); #1;
        mcand = 32'h00000055; mplier = 32'hFFFFFFFF; start = 1'b1; alu_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("pre_rst_req", 64'(alu_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_req", 64'(alu_req), 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        $display("reset abort: busy=%0d done=%0d alu_req=%0d prod=%h_%h",
                 busy, done, alu_req, prod_hi, prod_lo);
        @(posedge clk); #3;
        rst = 1'b0;
        run_mul(32'h00000003, 32'h00000004, 0, -1, 64'h00000000_0000000C, 32, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 32x32 multiply sequencer built on the shared combinational ALU. It implements a shift-and-add loop: each partial-sum addition goes through the ALU's add operation, and the 64-bit product shift is done in local registers. It sits beside the main datapath, which owns the ALU and lends it to this block through a request/grant pair.

## Interface
Parameters:
- OP_ADD, 4'b0001: ALU opcode for 32-bit add that also updates carry.
- OP_PASS, 4'b0000: ALU opcode driven when this block is not using the ALU (result = a).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request a multiply; accepted only in IDLE.
- mcand  in  32  multiplicand; sampled when start is accepted.
- mplier  in  32  multiplier; sampled when start is accepted.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the product is valid.
- prod_hi  out  32  upper word of the product.
- prod_lo  out  32  lower word of the product.
- alu_req  out  1  request for the shared ALU in this cycle.
- alu_gnt  in  1  datapath grants the ALU for this cycle.
- alu_a  out  32  ALU operand a (the current hi register).
- alu_b  out  32  ALU operand b (the latched multiplicand).
- alu_op  out  4  OP_ADD when alu_req is high, otherwise OP_PASS.
- alu_shamt  out  5  tied to 0.
- alu_result  in  32  ALU result, combinational in the same cycle.
- alu_carry  in  1  ALU carry-out for OP_ADD, same cycle.

## Operation
- Registers:
  - mc (32): latched multiplicand.
  - hi (32) and lo (32): the running product.
  - cnt (6): completed-iteration count.
  - state: IDLE, RUN or DONE.
- IDLE:
  - On start, load mc=mcand, hi=0, lo=mplier, cnt=0, and go to RUN.
  - start is ignored in RUN and DONE; it is not queued.
- RUN, one iteration per cycle:
  - If lo[0]=0: no ALU use (alu_req=0). Shift {0,hi,lo} right by 1 and increment cnt.
  - If lo[0]=1 and alu_gnt=1: sample alu_result and alu_carry. Set {hi,lo} = {alu_carry, alu_result, lo} >> 1 (the 65-bit value shifted right by 1) and increment cnt.
  - If lo[0]=1 and alu_gnt=0: stall. Hold all registers; alu_req stays high.
  - When the 32nd iteration completes (cnt becomes 32), go to DONE.
- DONE:
  - done=1 for this single cycle.
  - Next edge returns to IDLE unconditionally.
- Outputs:
  - prod_hi = hi and prod_lo = lo at all times.
  - Values are meaningful from the DONE cycle until the next accepted start.
- alu_req = (state==RUN) & lo[0]. It is combinational from state and lo, with no dependency on alu_gnt.
- alu_a and alu_b are driven continuously with hi and mc.
  - alu_op = OP_ADD only while alu_req=1, so ALU contents are undisturbed otherwise.
- Arithmetic:
  - Unsigned only.
  - The 65-bit intermediate {carry,hi} must not lose the carry.
  - The result is the exact 64-bit product modulo nothing, i.e. full width.

## Timing
- Reset values: state=IDLE, busy=0, done=0, alu_req=0, alu_op=OP_PASS, prod_hi=0, prod_lo=0, cnt=0, mc=0.
- Edge numbering: start is sampled high in IDLE at edge E0.
- busy is high from E0 until the edge leaving DONE.
- Latency with no stalls: 32 iterations at edges E1..E32. done is high in the cycle after E32, i.e. 32 cycles after E0. busy falls at E33.
- Each cycle with alu_req=1 and alu_gnt=0 adds exactly one cycle of latency.
- The earliest next start is accepted at E33, when state is back in IDLE.
- alu_gnt is ignored whenever alu_req=0.
- Reset during RUN or DONE:
  - Immediate return to IDLE and all registers cleared.
  - No done pulse for the aborted operation.
  - alu_req drops asynchronously with rst.

## Test plan
- alu_gnt tied 1, start with mcand=0x0000000A, mplier=0x00000003 -> prod_hi=0x00000000, prod_lo=0x0000001E; done exactly 32 cycles after the start edge; busy=1 for 33 cycles.
- alu_gnt tied 1, mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001. This proves carry capture.
- mcand=0x12345678, mplier=0x00000000 -> alu_req never asserts; prod=0; done at start+32.
- mcand=0x00000007, mplier=0x00000005 with alu_gnt held 0 for the first 5 cycles of RUN -> alu_req stays high during the stall; done at start+37; prod_lo=0x00000023.
- start pulsed again while busy, with different operands -> ignored; the first product is unchanged and there is no second done.
- rst asserted 10 cycles into RUN -> busy, done, alu_req and prod_* are 0 immediately. A following start with 3x4 yields prod_lo=0x0000000C.
